sram_axi_bridge: RTL and testbench

Converts the core's two SRAM-like ports (instruction fetch, data load/store) into a single AXI4 master on the top-level bus. It sits directly downstream of the core and the data-side address splitter, and drives the top-level `ar*/r*/aw*/w*/b*` pins. It serializes all traffic through one state machine and holds the requesting port in stall until its bus transaction completes.

---
 rtl/sram_axi_bridge_pkg.sv | 18 +
 rtl/sram_axi_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_axi_bridge_pkg.sv
// Shared constants for the SRAM-to-AXI bridge: fixed AXI encodings and FSM states.
package sram_axi_bridge_pkg;

  localparam logic [2:0] SIZE_4B    = 3'd2;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_I_AR,
    S_I_R,
    S_D_AR,
    S_D_R,
    S_D_AW,
    S_D_B,
    S_DONE
  } bridge_state_e;

endpackage

// File: rtl/sram_axi_bridge.sv
// Serializes the core's fetch and data SRAM-like ports onto one AXI master.
// One transaction at a time; data wins over fetch when both ask in IDLE.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_en,
  input  logic [31:0] inst_addr,
  output logic [63:0] inst_rdata,
  output logic        inst_stall,
  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_stall,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  bridge_state_e r_state;
  logic          r_owner_data;
  logic          r_arvalid, r_awvalid, r_wvalid, r_rready, r_bready;
  logic [3:0]    r_arid, r_arlen, r_wstrb;
  logic [31:0]   r_araddr, r_awaddr, r_wdata, r_data_rdata;
  logic [63:0]   r_inst_rdata;

  logic w_aw_hs, w_w_hs, w_aw_done, w_w_done, w_done_inst, w_done_data;
  logic w_unused;

  assign w_aw_hs   = r_awvalid & awready;
  assign w_w_hs    = r_wvalid & wready;
  // A dropped valid inside D_AW means that channel already handshook.
  assign w_aw_done = ~r_awvalid | w_aw_hs;
  assign w_w_done  = ~r_wvalid | w_w_hs;

  assign w_done_inst = (r_state == S_DONE) & ~r_owner_data;
  assign w_done_data = (r_state == S_DONE) & r_owner_data;
  assign inst_stall  = inst_en & ~w_done_inst;
  assign data_stall  = data_en & ~w_done_data;

  assign w_unused = ^{rid, rresp, bid, bresp, inst_addr[2:0]};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_owner_data <= 1'b0;
      r_arvalid    <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_rready     <= 1'b0;
      r_bready     <= 1'b0;
      r_arid       <= '0;
      r_arlen      <= '0;
      r_araddr     <= '0;
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (data_en) begin
            r_owner_data <= 1'b1;
            if (data_wen != 4'd0) begin
              r_state   <= S_D_AW;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_awaddr  <= data_addr;
              r_wdata   <= data_wdata;
              r_wstrb   <= data_wen;
            end else begin
              r_state   <= S_D_AR;
              r_arvalid <= 1'b1;
              r_araddr  <= data_addr;
              r_arlen   <= 4'd0;
              r_arid    <= DATA_ID;
            end
          end else if (inst_en) begin
            r_owner_data <= 1'b0;
            r_state      <= S_I_AR;
            r_arvalid    <= 1'b1;
            r_araddr     <= {inst_addr[31:3], 3'b000};
            r_arlen      <= 4'd1;
            r_arid       <= INST_ID;
          end
        end
        S_I_AR, S_D_AR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= (r_state == S_I_AR) ? S_I_R : S_D_R;
          end
        end
        S_I_R: begin
          if (rvalid) begin
            if (rlast) begin
              r_inst_rdata[63:32] <= rdata;
              r_rready            <= 1'b0;
              r_state             <= S_DONE;
            end else begin
              r_inst_rdata[31:0] <= rdata;
            end
          end
        end
        S_D_R: begin
          if (rvalid) begin
            r_data_rdata <= rdata;
            r_rready     <= 1'b0;
            r_state      <= S_DONE;
          end
        end
        S_D_AW: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_D_B;
          end
        end
        S_D_B: begin
          if (bvalid) begin
            r_bready <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = r_arvalid;
  assign rready  = r_rready;

  assign awid    = DATA_ID;
  assign awaddr  = r_awaddr;
  assign awlen   = 4'd0;
  assign awsize  = SIZE_4B;
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awvalid = r_awvalid;

  assign wid     = DATA_ID;
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wlast   = 1'b1;
  assign wvalid  = r_wvalid;
  assign bready  = r_bready;

  assign inst_rdata = r_inst_rdata;
  assign data_rdata = r_data_rdata;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: slave responses are scripted cycle by cycle.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic [63:0] inst_rdata;
  logic        inst_stall;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_stall;
  logic [3:0]  arid, arlen, arcache, rid, awid, awlen, awcache, wid, wstrb, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_stall(inst_stall),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_stall(data_stall),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; inst_en = 1'b0; inst_addr = '0;
    data_en = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = 4'hF; rresp = 2'b11;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 4'hF; bresp = 2'b11;
    nxt(); nxt();
    inst_en = 1'b1; #1;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got=%h exp=0", arvalid); end
    checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL reset_awvalid got=%h exp=0", awvalid); end
    checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid got=%h exp=0", wvalid); end
    checks++; if ({rready, bready} !== 2'b00) begin errors++; $display("FAIL reset_readies got=%b exp=00", {rready, bready}); end
    checks++; if (inst_rdata !== 64'd0) begin errors++; $display("FAIL reset_inst_rdata got=%h exp=0", inst_rdata); end
    checks++; if (data_rdata !== 32'd0) begin errors++; $display("FAIL reset_data_rdata got=%h exp=0", data_rdata); end
    checks++; if (inst_stall !== 1'b1) begin errors++; $display("FAIL reset_inst_stall got=%h exp=1", inst_stall); end
    checks++; if (data_stall !== 1'b0) begin errors++; $display("FAIL reset_data_stall got=%h exp=0", data_stall); end
    nxt();
    inst_en = 1'b0; resetn = 1'b1; #1;
    checks++; if (inst_stall !== 1'b0) begin errors++; $display("FAIL reset_release_stall got=%h exp=0", inst_stall); end
    nxt();
  endtask

  // Called in the IDLE cycle N; ends one cycle after DONE with inst_en dropped.
  task automatic run_fetch(input logic [31:0] addr, input logic [31:0] b0, input logic [31:0] b1);
    logic [31:0] exp_a;
    exp_a = {addr[31:3], 3'b000};
    inst_en = 1'b1; inst_addr = addr; #1;
    checks++; if (inst_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_n got=%h exp=1", inst_stall); end
    nxt(); arready = 1'b1; #1;
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL fetch_arvalid got=%h exp=1", arvalid); end
    checks++; if (araddr !== exp_a) begin errors++; $display("FAIL fetch_araddr got=%h exp=%h", araddr, exp_a); end
    checks++; if ({arid, arlen} !== 8'h01) begin errors++; $display("FAIL fetch_arid_arlen got=%h exp=01", {arid, arlen}); end
    checks++; if ({arsize, arburst} !== 5'b010_01) begin errors++; $display("FAIL fetch_size_burst got=%b exp=01001", {arsize, arburst}); end
    nxt(); arready = 1'b0; rvalid = 1'b1; rdata = b0; rlast = 1'b0; #1;
    checks++; if ({arvalid, rready} !== 2'b01) begin errors++; $display("FAIL fetch_ir_handshake got=%b exp=01", {arvalid, rready}); end
    nxt(); rdata = b1; rlast = 1'b1; #1;
    checks++; if (inst_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_n3 got=%h exp=1", inst_stall); end
    nxt(); rvalid = 1'b0; rlast = 1'b0; #1;
    checks++; if (inst_stall !== 1'b0) begin errors++; $display("FAIL fetch_stall_done got=%h exp=0", inst_stall); end
    checks++; if (inst_rdata !== {b1, b0}) begin errors++; $display("FAIL fetch_rdata got=%h exp=%h", inst_rdata, {b1, b0}); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL fetch_rready_done got=%h exp=0", rready); end
    nxt(); inst_en = 1'b0; #1;
  endtask

  task automatic test_fetch();
    run_fetch(32'hBFC0_0004, 32'h1111_1111, 32'h2222_2222);
    $display("fetch 0xBFC00004 -> inst_rdata=%h", inst_rdata);
    nxt();
  endtask

  task automatic test_load_ar_wait();
    data_en = 1'b1; data_wen = 4'd0; data_addr = 32'h8000_0010; #1;
    checks++; if (data_stall !== 1'b1) begin errors++; $display("FAIL load_stall_n got=%h exp=1", data_stall); end
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL load_arvalid_wait%0d got=%h exp=1", i, arvalid); end
      checks++; if (araddr !== 32'h8000_0010) begin errors++; $display("FAIL load_araddr_wait%0d got=%h exp=80000010", i, araddr); end
    end
    nxt(); arready = 1'b1; #1;
    checks++; if ({arvalid, arid, arlen} !== 9'h110) begin errors++; $display("FAIL load_ar_fields got=%h exp=110", {arvalid, arid, arlen}); end
    nxt(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rlast = 1'b1; #1;
    checks++; if ({arvalid, rready} !== 2'b01) begin errors++; $display("FAIL load_dr got=%b exp=01", {arvalid, rready}); end
    nxt(); rvalid = 1'b0; rlast = 1'b0; #1;
    checks++; if (data_stall !== 1'b0) begin errors++; $display("FAIL load_stall_done got=%h exp=0", data_stall); end
    checks++; if (data_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata got=%h exp=deadbeef", data_rdata); end
    $display("load 0x80000010 (arready +3) -> data_rdata=%h", data_rdata);
    nxt(); data_en = 1'b0; #1;
    nxt();
  endtask

  task automatic test_store_w_first();
    data_en = 1'b1; data_wen = 4'b0011; data_addr = 32'h8000_0020; data_wdata = 32'hCAFE_F00D; #1;
    nxt(); wready = 1'b1; #1;
    checks++; if ({awvalid, wvalid, wlast} !== 3'b111) begin errors++; $display("FAIL store_valids got=%b exp=111", {awvalid, wvalid, wlast}); end
    checks++; if (awaddr !== 32'h8000_0020) begin errors++; $display("FAIL store_awaddr got=%h exp=80000020", awaddr); end
    checks++; if (wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL store_wdata got=%h exp=cafef00d", wdata); end
    checks++; if (wstrb !== 4'b0011) begin errors++; $display("FAIL store_wstrb got=%b exp=0011", wstrb); end
    checks++; if ({awid, wid, awlen} !== 12'h110) begin errors++; $display("FAIL store_ids_len got=%h exp=110", {awid, wid, awlen}); end
    nxt(); wready = 1'b0; awready = 1'b1; #1;
    checks++; if ({awvalid, wvalid, bready} !== 3'b100) begin errors++; $display("FAIL store_w_dropped got=%b exp=100", {awvalid, wvalid, bready}); end
    checks++; if (awaddr !== 32'h8000_0020) begin errors++; $display("FAIL store_awaddr_hold got=%h exp=80000020", awaddr); end
    nxt(); awready = 1'b0; #1;
    checks++; if ({awvalid, bready, data_stall} !== 3'b011) begin errors++; $display("FAIL store_db_wait got=%b exp=011", {awvalid, bready, data_stall}); end
    nxt(); bvalid = 1'b1; #1;
    checks++; if ({bready, data_stall} !== 2'b11) begin errors++; $display("FAIL store_db got=%b exp=11", {bready, data_stall}); end
    nxt(); bvalid = 1'b0; #1;
    checks++; if ({bready, data_stall} !== 2'b00) begin errors++; $display("FAIL store_done got=%b exp=00", {bready, data_stall}); end
    $display("store 0x80000020 wen=0011 (W before AW) -> done");
    nxt(); data_en = 1'b0; data_wen = 4'd0; #1;
    nxt();
  endtask

  task automatic test_store_same_cycle();
    data_en = 1'b1; data_wen = 4'b1111; data_addr = 32'h8000_0030; data_wdata = 32'h0BAD_F00D; #1;
    nxt(); wready = 1'b1; awready = 1'b1; #1;
    checks++; if ({awvalid, wvalid} !== 2'b11) begin errors++; $display("FAIL store2_valids got=%b exp=11", {awvalid, wvalid}); end
    nxt(); wready = 1'b0; awready = 1'b0; bvalid = 1'b1; #1;
    checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin errors++; $display("FAIL store2_to_db got=%b exp=001", {awvalid, wvalid, bready}); end
    nxt(); bvalid = 1'b0; #1;
    checks++; if (data_stall !== 1'b0) begin errors++; $display("FAIL store2_done got=%h exp=0", data_stall); end
    $display("store 0x80000030 wen=1111 (AW+W same cycle) -> done");
    nxt(); data_en = 1'b0; data_wen = 4'd0; #1;
    nxt();
  endtask

  task automatic test_back_to_back();
    inst_en = 1'b1; inst_addr = 32'h0000_1008;
    data_en = 1'b1; data_wen = 4'd0; data_addr = 32'h8000_0040; #1;
    nxt(); arready = 1'b1; #1;
    checks++; if ({arvalid, arid, arlen} !== 9'h110) begin errors++; $display("FAIL b2b_data_ar got=%h exp=110", {arvalid, arid, arlen}); end
    checks++; if (araddr !== 32'h8000_0040) begin errors++; $display("FAIL b2b_data_araddr got=%h exp=80000040", araddr); end
    checks++; if (inst_stall !== 1'b1) begin errors++; $display("FAIL b2b_istall_ar got=%h exp=1", inst_stall); end
    nxt(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678; rlast = 1'b1; #1;
    checks++; if (inst_stall !== 1'b1) begin errors++; $display("FAIL b2b_istall_r got=%h exp=1", inst_stall); end
    nxt(); rvalid = 1'b0; rlast = 1'b0; #1;
    checks++; if ({data_stall, inst_stall} !== 2'b01) begin errors++; $display("FAIL b2b_done_stalls got=%b exp=01", {data_stall, inst_stall}); end
    checks++; if (data_rdata !== 32'h1234_5678) begin errors++; $display("FAIL b2b_data_rdata got=%h exp=12345678", data_rdata); end
    nxt(); data_en = 1'b0; #1;
    checks++; if ({arvalid, inst_stall} !== 2'b01) begin errors++; $display("FAIL b2b_idle got=%b exp=01", {arvalid, inst_stall}); end
    run_fetch(32'h0000_1008, 32'hAAAA_0001, 32'hBBBB_0002);
    $display("back-to-back load 0x80000040 then fetch 0x00001008 -> %h / %h", data_rdata, inst_rdata);
    nxt();
  endtask

  task automatic test_reset_midflight();
    inst_en = 1'b1; inst_addr = 32'hBFC0_0008; #1;
    nxt(); arready = 1'b1; #1;
    nxt(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hAAAA_5555; rlast = 1'b0; #1;
    nxt(); rvalid = 1'b0; resetn = 1'b0; #1;
    checks++; if (inst_rdata[31:0] !== 32'hAAAA_5555) begin errors++; $display("FAIL rstmid_beat0 got=%h exp=aaaa5555", inst_rdata[31:0]); end
    nxt(); #1;
    checks++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin errors++; $display("FAIL rstmid_handshake got=%b exp=00000", {arvalid, awvalid, wvalid, rready, bready}); end
    checks++; if (inst_rdata !== 64'd0) begin errors++; $display("FAIL rstmid_inst_rdata got=%h exp=0", inst_rdata); end
    checks++; if (data_rdata !== 32'd0) begin errors++; $display("FAIL rstmid_data_rdata got=%h exp=0", data_rdata); end
    checks++; if (inst_stall !== 1'b1) begin errors++; $display("FAIL rstmid_stall got=%h exp=1", inst_stall); end
    inst_en = 1'b0;
    nxt(); resetn = 1'b1; #1;
    nxt();
    run_fetch(32'hBFC0_0014, 32'h3333_3333, 32'h4444_4444);
    $display("reset during I_R, then fetch 0xBFC00014 -> inst_rdata=%h", inst_rdata);
    nxt();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_load_ar_wait();
    test_store_w_first();
    test_store_same_cycle();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
